// File: rtl/uart_rx_pkg.sv
// Shared UART link settings, FSM state type and divisor helpers.
// uart_tx imports the same package so both ends of a link agree.
package uart_rx_pkg;

  localparam int unsigned DefaultBaud    = 115200;
  localparam int unsigned DefaultClkFreq = 27_000_000;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } uart_state_e;

  // Last value of the per-bit cycle counter.
  function automatic int unsigned clk_cnt_max(input int unsigned clk_freq,
                                              input int unsigned baud);
    return (clk_freq / baud) - 1;
  endfunction

  function automatic int unsigned half_cnt(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_cnt_max(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus one delay flop
// used to detect the falling start edge.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic rx,
  output logic rx_s,
  output logic start_fall
);

  logic meta_q;
  logic rx_s_q;
  logic rx_d_q;

  // Reset to the idle line level so reset never fakes a start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      meta_q <= rx;
      rx_s_q <= meta_q;
      rx_d_q <= rx_s_q;
    end
  end

  assign rx_s       = rx_s_q;
  assign start_fall = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Bits are sampled mid-bit, timed only from
// the start edge; good bytes appear on po_data with a one-cycle po_flag.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD     = DefaultBaud,
  parameter int unsigned CLK_FREQ = DefaultClkFreq
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned ClkCntMaxI = clk_cnt_max(CLK_FREQ, BAUD);
  localparam int unsigned HalfCntI   = half_cnt(CLK_FREQ, BAUD);
  localparam logic [15:0] ClkCntMax  = ClkCntMaxI[15:0];
  localparam logic [15:0] HalfCnt    = HalfCntI[15:0];

  if (ClkCntMaxI > 32'd65535 || ClkCntMaxI < 32'd7) begin : g_bad_cfg
    $error("uart_rx: CLK_FREQ/BAUD gives an unusable bit divisor");
  end

  logic rx_s;
  logic start_fall;

  uart_rx_sync u_sync (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rx         (rx),
    .rx_s       (rx_s),
    .start_fall (start_fall)
  );

  uart_state_e state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  po_data_q, po_data_d;
  logic        po_flag_q, po_flag_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;
  logic        cnt_at_max;

  assign cnt_at_max = (clk_cnt_q == ClkCntMax);

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    po_data_d   = po_data_q;
    po_flag_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = 16'd0;
        if (start_fall) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (clk_cnt_q == HalfCnt) begin
          clk_cnt_d = 16'd0;
          bit_cnt_d = 3'd0;
          // A line that is high again at mid start bit was only a glitch.
          state_d   = rx_s ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_at_max) begin
          clk_cnt_d = 16'd0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_at_max) begin
          clk_cnt_d = 16'd0;
          if (rx_s) begin
            po_data_d = shift_q;
            po_flag_d = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StBreak: begin
        // Hold off until the line idles so a stuck-low line cannot retrigger.
        if (rx_s) begin
          clk_cnt_d = 16'd0;
          state_d   = StIdle;
        end else begin
          clk_cnt_d = cnt_at_max ? 16'd0 : clk_cnt_q + 16'd1;
        end
      end
      default: begin
        clk_cnt_d = 16'd0;
        state_d   = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      clk_cnt_q   <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      po_data_q   <= 8'h00;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      po_data_q   <= po_data_d;
      po_flag_q   <= po_flag_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign po_data   = po_data_q;
  assign po_flag   = po_flag_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial line driver feeds frames, a
// scoreboard queue holds the bytes that should come out on po_flag.
module tb_uart_rx;

  localparam int unsigned BitPer  = 234;
  localparam int unsigned HalfCnt = 116;
  localparam int unsigned LatNom  = 2225;

  logic       sys_clk;
  logic       sys_rst;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       busy;

  uart_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx        (rx),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int unsigned total;
  int unsigned bad;
  int unsigned cyc;
  int unsigned flag_cnt;
  int unsigned ferr_cnt;
  int unsigned busy_cnt;
  int unsigned last_flag_cyc;
  int unsigned start_cyc;
  logic        mon_en;
  logic [7:0]  last_data;
  logic [7:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every po_flag strobe.
  always @(posedge sys_clk) begin
    #1;
    if (sys_rst) begin
      last_data = 8'h00;
    end else if (mon_en) begin
      if (busy) busy_cnt++;
      if (frame_err) ferr_cnt++;
      if (po_flag && frame_err) chk("flag_and_err", 32'd1, 32'd0);
      if (po_flag) begin
        flag_cnt++;
        last_flag_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("spurious_flag", 32'd1, 32'd0);
        end else begin
          last_data = exp_q.pop_front();
          chk("byte", {24'd0, po_data}, {24'd0, last_data});
        end
      end else if (po_data !== last_data) begin
        chk("data_stable", {24'd0, po_data}, {24'd0, last_data});
      end
    end
  end

  // Drives nbits of a frame (start, 8 data LSB first, stop); call at a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int unsigned period, input int unsigned nbits);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    if (nbits == 10 && stop_bit) exp_q.push_back(b);
    for (int i = 0; i < int'(nbits); i++) begin
      rx = bits[i];
      if (i == 0) start_cyc = cyc;
      repeat (period) @(negedge sys_clk);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int unsigned f0;
  int unsigned e0;
  int unsigned lat;

  initial begin
    total = 0; bad = 0; cyc = 0; flag_cnt = 0; ferr_cnt = 0; busy_cnt = 0;
    last_flag_cyc = 0; start_cyc = 0; mon_en = 1'b0; last_data = 8'h00;
    rx = 1'b1;
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("rst_data", {24'd0, po_data}, 32'h00);
    chk("rst_flag", {31'd0, po_flag}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    sys_rst = 1'b0;
    mon_en  = 1'b1;
    repeat (20) @(negedge sys_clk);

    // Nominal 0xA5 frame with latency window.
    send_frame(8'hA5, 1'b1, BitPer, 10);
    repeat (20) @(negedge sys_clk);
    chk("a5_flags", flag_cnt, 32'd1);
    chk("a5_ferr", ferr_cnt, 32'd0);
    lat = last_flag_cyc - start_cyc;
    $display("info: 0xA5 latency %0d cycles", lat);
    chk("a5_latency_ok", {31'd0, (lat + 4 >= LatNom) && (lat <= LatNom + 4)}, 32'd1);
    chk("a5_busy_idle", {31'd0, busy}, 32'd0);

    // 50-cycle low glitch: START is left at HALF_CNT with no strobes.
    busy_cnt = 0;
    rx = 1'b0;
    repeat (50) @(negedge sys_clk);
    rx = 1'b1;
    repeat (300) @(negedge sys_clk);
    $display("info: glitch busy for %0d cycles", busy_cnt);
    chk("glitch_busy_len_ok",
        {31'd0, (busy_cnt >= HalfCnt - 1) && (busy_cnt <= HalfCnt + 3)}, 32'd1);
    chk("glitch_flags", flag_cnt, 32'd1);
    chk("glitch_ferr", ferr_cnt, 32'd0);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);

    // 0x3C with low stop bit, then line held low for 3 bit times.
    send_frame(8'h3C, 1'b0, BitPer, 10);
    rx = 1'b0;
    repeat (3 * BitPer) @(negedge sys_clk);
    chk("ferr_count", ferr_cnt, 32'd1);
    chk("ferr_busy_held", {31'd0, busy}, 32'd1);
    chk("ferr_data_kept", {24'd0, po_data}, 32'hA5);
    rx = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("ferr_busy_released", {31'd0, busy}, 32'd0);
    repeat (2600) @(negedge sys_clk);
    chk("ferr_no_retrigger_flag", flag_cnt, 32'd1);
    chk("ferr_no_retrigger_err", ferr_cnt, 32'd1);

    // Back-to-back frames, as a uart_tx loopback would produce.
    f0 = flag_cnt;
    e0 = ferr_cnt;
    send_frame(8'h00, 1'b1, BitPer, 10);
    send_frame(8'hFF, 1'b1, BitPer, 10);
    send_frame(8'h55, 1'b1, BitPer, 10);
    send_frame(8'h80, 1'b1, BitPer, 10);
    repeat (20) @(negedge sys_clk);
    chk("loop_flags", flag_cnt - f0, 32'd4);
    chk("loop_ferr", ferr_cnt - e0, 32'd0);

    // Reset mid-DATA of 0x77 while the line is high (after data bit 2).
    f0 = flag_cnt;
    send_frame(8'h77, 1'b1, BitPer, 4);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("mid_rst_data", {24'd0, po_data}, 32'h00);
    chk("mid_rst_flag", {31'd0, po_flag}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    rx = 1'b1;
    repeat (3000) @(negedge sys_clk);
    chk("mid_rst_no_flag", flag_cnt - f0, 32'd0);
    send_frame(8'h12, 1'b1, BitPer, 10);
    repeat (20) @(negedge sys_clk);
    chk("after_rst_flags", flag_cnt - f0, 32'd1);
    chk("after_rst_data", {24'd0, po_data}, 32'h12);

    // Baud skew: +2% (shorter bits) and -2% (longer bits).
    f0 = flag_cnt;
    send_frame(8'hC3, 1'b1, 229, 10);
    repeat (50) @(negedge sys_clk);
    chk("fast_data", {24'd0, po_data}, 32'hC3);
    send_frame(8'hC3, 1'b1, 239, 10);
    repeat (50) @(negedge sys_clk);
    chk("slow_data", {24'd0, po_data}, 32'hC3);
    chk("skew_flags", flag_cnt - f0, 32'd2);
    chk("skew_ferr", ferr_cnt, 32'd1);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
